// File: rtl/i2c_write_master_pkg.sv
// Shared types and constants for the single-byte I2C write master.
// Also holds the per-state SCL/SDA drive table, so every bus level lives in one place.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK_A = 3'd3,
    DATA  = 3'd4,
    ACK_D = 3'd5,
    STOP  = 3'd6
  } i2c_state_t;

  typedef logic [1:0] qtr_t;

  localparam logic        I2C_WRITE = 1'b0;
  localparam int unsigned ADDR_BITS = 8;
  localparam int unsigned DATA_BITS = 8;

  // Returns {scl, sda} for a state/quarter; b is the bit shown during data slots.
  function automatic logic [1:0] bus_drive(input i2c_state_t s, input qtr_t q, input logic b);
    logic [1:0] d;
    d = 2'b11;
    case (s)
      START:        d = (q == 2'd2) ? 2'b10 : ((q == 2'd3) ? 2'b00 : 2'b11);
      ADDR, DATA:   d = {q[1], b};
      ACK_A, ACK_D: d = {q[1], 1'b1};
      STOP:         d = (q == 2'd0) ? 2'b00 : ((q == 2'd1) ? 2'b10 : 2'b11);
      default:      d = 2'b11;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_write_master_if.sv
// Request, status and open-drain bus signals of the I2C write master.
interface i2c_write_master_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] data;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic       busy;
  logic       done;
  logic       nack;

  modport master (
    input  start, addr, data, sda_i,
    output scl_o, sda_o, busy, done, nack
  );

  modport slave (
    output start, addr, data, sda_i,
    input  scl_o, sda_o, busy, done, nack
  );
endinterface

// File: rtl/i2c_write_master_tick_gen.sv
// Quarter-period divider: o_qtick is high on the last clk cycle of every quarter.
// Cleared on accept so the first quarter of a transfer is always full length.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_qtick
);

  logic [7:0] r_cnt;
  logic       w_last;

  assign w_last  = (r_cnt == 8'(CLK_DIV - 1));
  assign o_qtick = w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_write_master.sv
// Single-byte I2C write initiator: START, address+W, data byte, STOP, with ACK sampling.
//   state | meaning
//   IDLE  | bus released, waiting for start
//   START | SDA falls while SCL high
//   ADDR  | 7-bit address + R/W=0, MSB first
//   ACK_A | SDA released, target ACK to address sampled
//   DATA  | data byte, MSB first
//   ACK_D | SDA released, target ACK to data sampled
//   STOP  | SDA rises while SCL high, then back to IDLE
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  i2c_write_master_if.master   io_bus
);

  i2c_state_t r_state, w_state_nxt;
  qtr_t       r_q, w_q_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_nack, w_nack_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_scl, w_scl_nxt;
  logic       r_sda, w_sda_nxt;
  logic       w_accept;
  logic       w_qtick;

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_accept),
    .o_qtick (w_qtick)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_nack  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_nack  <= w_nack_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_scl   <= w_scl_nxt;
      r_sda   <= w_sda_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_nack_nxt  = r_nack;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;

    if (r_state == IDLE) begin
      if (io_bus.start) begin
        w_accept    = 1'b1;
        w_state_nxt = START;
        w_q_nxt     = '0;
        w_bit_nxt   = '0;
        w_shift_nxt = {io_bus.addr, I2C_WRITE};
        w_data_nxt  = io_bus.data;
        w_nack_nxt  = 1'b0;
        w_busy_nxt  = 1'b1;
      end
    end else if (w_qtick) begin
      w_q_nxt = r_q + 2'd1;
      // SCL has been high for the whole of Q2, so its last cycle is a safe sample point.
      if ((r_state == ACK_A || r_state == ACK_D) && r_q == 2'd2) begin
        w_nack_nxt = r_nack | io_bus.sda_i;
      end
      if (r_q == 2'd3) begin
        case (r_state)
          START: begin
            w_state_nxt = ADDR;
            w_bit_nxt   = '0;
          end
          ADDR: begin
            if (r_bit == 3'(ADDR_BITS - 1)) begin
              w_state_nxt = ACK_A;
              w_bit_nxt   = '0;
            end else begin
              w_bit_nxt   = r_bit + 3'd1;
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
          ACK_A: begin
            if (r_nack) begin
              w_state_nxt = STOP;
            end else begin
              w_state_nxt = DATA;
              w_shift_nxt = r_data;
              w_bit_nxt   = '0;
            end
          end
          DATA: begin
            if (r_bit == 3'(DATA_BITS - 1)) begin
              w_state_nxt = ACK_D;
              w_bit_nxt   = '0;
            end else begin
              w_bit_nxt   = r_bit + 3'd1;
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
          ACK_D: begin
            w_state_nxt = STOP;
          end
          STOP: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
          default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end
        endcase
      end
    end

    // Drive levels come from the next state so they appear on the quarter's first cycle.
    {w_scl_nxt, w_sda_nxt} = bus_drive(w_state_nxt, w_q_nxt, w_shift_nxt[7]);
  end

  assign io_bus.scl_o = r_scl;
  assign io_bus.sda_o = r_sda;
  assign io_bus.busy  = r_busy;
  assign io_bus.done  = r_done;
  assign io_bus.nack  = r_nack;

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench: CLK_DIV=4 instance with an ACKing target and bus monitor,
// plus a CLK_DIV=1 instance for back-to-back timing.
module tb_i2c_write_master;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  i2c_write_master_if bus4();
  i2c_write_master_if bus1();

  i2c_write_master #(.CLK_DIV(4)) u_dut4 (.i_clk(clk), .i_reset(reset), .io_bus(bus4));
  i2c_write_master #(.CLK_DIV(1)) u_dut1 (.i_clk(clk), .i_reset(reset), .io_bus(bus1));

  // Target model + bus monitor on the CLK_DIV=4 bus (wired-AND SDA)
  localparam logic [1:0] M_IDLE = 2'd0, M_ACTIVE = 2'd1, M_END = 2'd2;
  logic        r_pull = 1'b0;
  logic        ack_a_en = 1'b0, ack_d_en = 1'b0, mon_clr = 1'b0;
  logic        m_scl_q = 1'b1, m_sda_q = 1'b1;
  logic [1:0]  m_state = M_IDLE;
  int          n_start = 0, n_stop = 0, rise_cnt = 0;
  logic [31:0] bits = '0;

  assign bus4.sda_i = bus4.sda_o & ~r_pull;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_start <= 0; n_stop <= 0; rise_cnt <= 0; bits <= '0; r_pull <= 1'b0; m_state <= M_IDLE;
    end else begin
      if (m_scl_q && bus4.scl_o && m_sda_q && !bus4.sda_i) begin
        n_start <= n_start + 1; m_state <= M_ACTIVE; rise_cnt <= 0; bits <= '0;
      end else if (m_scl_q && bus4.scl_o && !m_sda_q && bus4.sda_i) begin
        n_stop <= n_stop + 1;
        if (m_state == M_ACTIVE) m_state <= M_END;
      end
      if (!m_scl_q && bus4.scl_o) begin
        rise_cnt <= rise_cnt + 1; bits <= {bits[30:0], bus4.sda_i};
      end
      if (m_scl_q && !bus4.scl_o)
        r_pull <= (rise_cnt == 8 && ack_a_en) || (rise_cnt == 17 && ack_d_en);
    end
    m_scl_q <= bus4.scl_o;
    m_sda_q <= bus4.sda_i;
  end

  task automatic mon_clear(input logic a, input logic d);
    ack_a_en = a; ack_d_en = d; mon_clr = 1'b1;
    @(negedge clk); #1; mon_clr = 1'b0;
  endtask

  // Runs one transfer on bus4 and returns what was observed.
  task automatic run_transfer(input logic [6:0] a, input logic [7:0] d, input logic poke,
                              output int cyc, output logic busy_e0, output logic busy_end,
                              output logic nack_end, output logic done_next, output logic nack_hold);
    @(negedge clk);
    bus4.addr = a; bus4.data = d; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    busy_e0 = bus4.busy;
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 50) begin bus4.start = 1'b1; bus4.addr = 7'h7F; bus4.data = 8'h00; end
      if (poke && cyc == 51) bus4.start = 1'b0;
      if (bus4.done === 1'b1) break;
    end
    busy_end = bus4.busy;
    nack_end = bus4.nack;
    @(posedge clk); #1;
    done_next = bus4.done;
    repeat (4) @(posedge clk);
    #1;
    nack_hold = bus4.nack;
  endtask

  task automatic test_reset();
    checks++; if (bus4.scl_o !== 1'b1) begin failures++; $display("FAIL reset_scl: got %b expected 1", bus4.scl_o); end
    checks++; if (bus4.sda_o !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b expected 1", bus4.sda_o); end
    checks++; if (bus4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus4.busy); end
    checks++; if (bus4.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus4.done); end
    checks++; if (bus4.nack !== 1'b0) begin failures++; $display("FAIL reset_nack: got %b expected 0", bus4.nack); end
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL reset_busy1: got %b expected 0", bus1.busy); end
  endtask

  task automatic test_ack_path();
    int cyc; logic be, bn, ne, dn, nh; logic [31:0] exp_bits;
    exp_bits = {13'b0, 7'h50, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    mon_clear(1'b1, 1'b1);
    run_transfer(7'h50, 8'hA5, 1'b0, cyc, be, bn, ne, dn, nh);
    checks++; if (be !== 1'b1) begin failures++; $display("FAIL ack_busy_e0: got %b expected 1", be); end
    checks++; if (cyc != 320) begin failures++; $display("FAIL ack_done_cycle: got %0d expected 320", cyc); end
    checks++; if (bn !== 1'b0) begin failures++; $display("FAIL ack_busy_end: got %b expected 0", bn); end
    checks++; if (ne !== 1'b0) begin failures++; $display("FAIL ack_nack: got %b expected 0", ne); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL ack_done_width: got %b expected 0", dn); end
    checks++; if (rise_cnt != 19) begin failures++; $display("FAIL ack_scl_rises: got %0d expected 19", rise_cnt); end
    checks++; if (bits !== exp_bits) begin failures++; $display("FAIL ack_bits: got %h expected %h", bits, exp_bits); end
    checks++; if (n_start != 1 || n_stop != 1) begin failures++; $display("FAIL ack_bus_edges: got start=%0d stop=%0d expected 1/1", n_start, n_stop); end
    checks++; if (m_state !== M_END) begin failures++; $display("FAIL ack_monitor_end: got %0d expected %0d", m_state, M_END); end
  endtask

  task automatic test_nack_addr();
    int cyc; logic be, bn, ne, dn, nh; logic [31:0] exp_bits;
    exp_bits = {22'b0, 7'h2B, 1'b0, 1'b1, 1'b0};
    mon_clear(1'b0, 1'b0);
    run_transfer(7'h2B, 8'hFF, 1'b0, cyc, be, bn, ne, dn, nh);
    checks++; if (cyc != 176) begin failures++; $display("FAIL nack_addr_cycle: got %0d expected 176", cyc); end
    checks++; if (ne !== 1'b1) begin failures++; $display("FAIL nack_addr_nack: got %b expected 1", ne); end
    checks++; if (nh !== 1'b1) begin failures++; $display("FAIL nack_addr_hold: got %b expected 1", nh); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL nack_addr_done_width: got %b expected 0", dn); end
    checks++; if (rise_cnt != 10) begin failures++; $display("FAIL nack_addr_rises: got %0d expected 10", rise_cnt); end
    checks++; if (bits !== exp_bits) begin failures++; $display("FAIL nack_addr_bits: got %h expected %h", bits, exp_bits); end
    checks++; if (n_start != 1 || n_stop != 1) begin failures++; $display("FAIL nack_addr_bus_edges: got start=%0d stop=%0d expected 1/1", n_start, n_stop); end
  endtask

  task automatic test_nack_data();
    int cyc; logic be, bn, ne, dn, nh; logic [31:0] exp_bits;
    exp_bits = {13'b0, 7'h3C, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    mon_clear(1'b1, 1'b0);
    run_transfer(7'h3C, 8'h5A, 1'b0, cyc, be, bn, ne, dn, nh);
    checks++; if (cyc != 320) begin failures++; $display("FAIL nack_data_cycle: got %0d expected 320", cyc); end
    checks++; if (ne !== 1'b1) begin failures++; $display("FAIL nack_data_nack: got %b expected 1", ne); end
    checks++; if (bits !== exp_bits) begin failures++; $display("FAIL nack_data_bits: got %h expected %h", bits, exp_bits); end
    checks++; if (m_state !== M_END) begin failures++; $display("FAIL nack_data_monitor_end: got %0d expected %0d", m_state, M_END); end
  endtask

  task automatic test_ignore_start();
    int cyc; logic be, bn, ne, dn, nh; logic [31:0] exp_bits;
    exp_bits = {13'b0, 7'h50, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    mon_clear(1'b1, 1'b1);
    run_transfer(7'h50, 8'hA5, 1'b1, cyc, be, bn, ne, dn, nh);
    checks++; if (cyc != 320) begin failures++; $display("FAIL ignore_start_cycle: got %0d expected 320", cyc); end
    checks++; if (bits !== exp_bits) begin failures++; $display("FAIL ignore_start_bits: got %h expected %h", bits, exp_bits); end
    checks++; if (ne !== 1'b0) begin failures++; $display("FAIL ignore_start_nack: got %b expected 0", ne); end
    checks++; if (nh !== 1'b0) begin failures++; $display("FAIL ignore_start_nack_hold: got %b expected 0", nh); end
  endtask

  task automatic test_reset_mid();
    int n_done;
    mon_clear(1'b1, 1'b1);
    @(negedge clk);
    bus4.addr = 7'h50; bus4.data = 8'hA5; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (99) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus4.scl_o !== 1'b1) begin failures++; $display("FAIL mid_reset_scl: got %b expected 1", bus4.scl_o); end
    checks++; if (bus4.sda_o !== 1'b1) begin failures++; $display("FAIL mid_reset_sda: got %b expected 1", bus4.sda_o); end
    checks++; if (bus4.busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", bus4.busy); end
    checks++; if (bus4.done !== 1'b0) begin failures++; $display("FAIL mid_reset_done: got %b expected 0", bus4.done); end
    reset = 1'b0;
    n_done = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1) n_done++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL mid_reset_no_done: got %0d expected 0", n_done); end
    checks++; if (bus4.busy !== 1'b0) begin failures++; $display("FAIL mid_reset_idle: got %b expected 0", bus4.busy); end
  endtask

  task automatic test_back_to_back();
    int n, pulses, wide; int t[3]; logic prev;
    pulses = 0; wide = 0; prev = 1'b0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    @(negedge clk);
    bus1.addr = 7'h12; bus1.data = 8'h34; bus1.start = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus1.busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_e0: got %b expected 1", bus1.busy); end
    n = 0;
    while (n < 400 && pulses < 3) begin
      @(posedge clk); #1;
      n++;
      if (bus1.done === 1'b1 && !prev) begin t[pulses] = n; pulses++; end
      if (bus1.done === 1'b1 && prev) wide++;
      prev = bus1.done;
    end
    @(posedge clk); #1;
    if (bus1.done === 1'b1) wide++;
    bus1.start = 1'b0;
    checks++; if (pulses != 3) begin failures++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
    checks++; if (t[0] != 80) begin failures++; $display("FAIL b2b_first_done: got %0d expected 80", t[0]); end
    checks++; if (t[1] - t[0] != 81) begin failures++; $display("FAIL b2b_period1: got %0d expected 81", t[1] - t[0]); end
    checks++; if (t[2] - t[1] != 81) begin failures++; $display("FAIL b2b_period2: got %0d expected 81", t[2] - t[1]); end
    checks++; if (wide != 0) begin failures++; $display("FAIL b2b_done_width: got %0d extra cycles expected 0", wide); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus4.start = 1'b0; bus4.addr = '0; bus4.data = '0;
    bus1.start = 1'b0; bus1.addr = '0; bus1.data = '0; bus1.sda_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_ack_path();
    test_nack_addr();
    test_nack_data();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
